// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with registered dout, ack/err handshake and almost flags.
// Optional high-water-mark output peak_count is enabled by defining FIFO_PEAK_CNT_EN.
module fifo_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err
`ifdef FIFO_PEAK_CNT_EN
  ,
  output logic [ADDR_WIDTH:0]   peak_count
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] head_q, head_d;
  logic [ADDR_WIDTH-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  wr_ack_q, wr_err_q, rd_ack_q, rd_err_q;
  logic                  wr_accept, rd_accept;

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign rd_accept = rd_en && !empty;
  assign wr_accept = wr_en && (!full || rd_en);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    dout_d  = '0;
    if (rd_accept) begin
      dout_d = mem_q[head_q];
      head_d = head_q + ADDR_WIDTH'(1);
    end
    if (wr_accept) begin
      tail_d = tail_q + ADDR_WIDTH'(1);
    end
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage is deliberately left out of reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[tail_q] <= din;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      wr_ack_q <= 1'b0;
      wr_err_q <= 1'b0;
      rd_ack_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      wr_ack_q <= wr_accept;
      wr_err_q <= wr_en && !wr_accept;
      rd_ack_q <= rd_accept;
      rd_err_q <= rd_en && !rd_accept;
    end
  end

  assign dout       = dout_q;
  assign data_count = count_q;
  assign wr_ack     = wr_ack_q;
  assign wr_err     = wr_err_q;
  assign rd_ack     = rd_ack_q;
  assign rd_err     = rd_err_q;

`ifdef FIFO_PEAK_CNT_EN
  logic [CNT_W-1:0] peak_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      peak_q <= '0;
    end else if (count_d > peak_q) begin
      peak_q <= count_d;
    end
  end

  assign peak_count = peak_q;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Directed self-checking bench for fifo_param (default 32x8, AF=6, AE=2).
// Covers fill/drain, overflow/underflow, simultaneous access at full/empty, wrap and async reset.
module tb_fifo_param;

  logic        clk;
  logic        reset_n;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] din;
  logic [31:0] dout;
  logic [3:0]  data_count;
  logic        full, empty, almost_full, almost_empty;
  logic        wr_ack, wr_err, rd_ack, rd_err;
`ifdef FIFO_PEAK_CNT_EN
  logic [3:0]  peak_count;
`endif

  int checks = 0;
  int errors = 0;

  fifo_param dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .din          (din),
    .dout         (dout),
    .data_count   (data_count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .wr_ack       (wr_ack),
    .wr_err       (wr_err),
    .rd_ack       (rd_ack),
    .rd_err       (rd_err)
`ifdef FIFO_PEAK_CNT_EN
    ,
    .peak_count   (peak_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected flags follow from occupancy with the default DEPTH=8, AF=6, AE=2.
  task automatic check_level(input string tag, input int n);
    check({tag, " data_count"},   64'(data_count),   64'(n));
    check({tag, " full"},         64'(full),         64'(n == 8));
    check({tag, " empty"},        64'(empty),        64'(n == 0));
    check({tag, " almost_full"},  64'(almost_full),  64'(n >= 6));
    check({tag, " almost_empty"}, 64'(almost_empty), 64'(n <= 2));
  endtask

  task automatic check_hs(input string tag, input logic wa, input logic we,
                          input logic ra, input logic re);
    check({tag, " wr_ack"}, 64'(wr_ack), 64'(wa));
    check({tag, " wr_err"}, 64'(wr_err), 64'(we));
    check({tag, " rd_ack"}, 64'(rd_ack), 64'(ra));
    check({tag, " rd_err"}, 64'(rd_err), 64'(re));
  endtask

  // One request cycle; outputs are sampled 1 time unit after the edge that registers it.
  task automatic cyc(input logic w, input logic r, input logic [31:0] d);
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
  endtask

  initial begin
    reset_n = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    din     = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_level("reset", 0);
    check("reset dout", 64'(dout), 64'h0);
    check_hs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef FIFO_PEAK_CNT_EN
    check("reset peak", 64'(peak_count), 64'h0);
`endif
    #3 reset_n = 1'b1;

    // Fill 0x1..0x8, then overflow
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 1'b0, 32'(i));
      check_hs("fill", 1'b1, 1'b0, 1'b0, 1'b0);
      check("fill dout", 64'(dout), 64'h0);
      check_level("fill", i);
    end
    cyc(1'b1, 1'b0, 32'h9);
    check_hs("overflow", 1'b0, 1'b1, 1'b0, 1'b0);
    check_level("overflow", 8);

    // Drain 0x1..0x8, then underflow
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 1'b1, '0);
      check("drain dout", 64'(dout), 64'(i));
      check_hs("drain", 1'b0, 1'b0, 1'b1, 1'b0);
      check_level("drain", 8 - i);
    end
    cyc(1'b0, 1'b1, '0);
    check("underflow dout", 64'(dout), 64'h0);
    check_hs("underflow", 1'b0, 1'b0, 1'b0, 1'b1);
    check_level("underflow", 0);

    // Simultaneous write and read while full
    for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 32'h10 + 32'(i));
    check_level("refill", 8);
    cyc(1'b1, 1'b1, 32'hAA);
    check("full wr+rd dout", 64'(dout), 64'h11);
    check_hs("full wr+rd", 1'b1, 1'b0, 1'b1, 1'b0);
    check_level("full wr+rd", 8);
    for (int i = 2; i <= 8; i++) begin
      cyc(1'b0, 1'b1, '0);
      check("drain2 dout", 64'(dout), 64'h10 + 64'(i));
    end
    cyc(1'b0, 1'b1, '0);
    check("drain2 last dout", 64'(dout), 64'hAA);
    check_level("drain2", 0);

    // Simultaneous write and read while empty
    cyc(1'b1, 1'b1, 32'h55);
    check_hs("empty wr+rd", 1'b1, 1'b0, 1'b0, 1'b1);
    check("empty wr+rd dout", 64'(dout), 64'h0);
    check_level("empty wr+rd", 1);
    cyc(1'b0, 1'b0, '0);
    check_hs("idle", 1'b0, 1'b0, 1'b0, 1'b0);
    check("idle dout", 64'(dout), 64'h0);
    cyc(1'b0, 1'b1, '0);
    check("read 55 dout", 64'(dout), 64'h55);
    check_level("read 55", 0);

    // Fresh reset so the high-water mark reflects only the wrap bursts
    reset_n = 1'b0;
    #2 reset_n = 1'b1;

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 32'h100 + 32'(r * 16 + i));
      check_level("wrap fill", 5);
      for (int i = 0; i < 5; i++) begin
        cyc(1'b0, 1'b1, '0);
        check("wrap dout", 64'(dout), 64'h100 + 64'(r * 16 + i));
      end
      check_level("wrap drain", 0);
    end

    // Asynchronous reset in the middle of a burst
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'h200 + 32'(i));
    cyc(1'b0, 1'b1, '0);
    check("pre-reset dout", 64'(dout), 64'h200);
    check_hs("pre-reset", 1'b0, 1'b0, 1'b1, 1'b0);
    check_level("pre-reset", 3);
`ifdef FIFO_PEAK_CNT_EN
    check("pre-reset peak", 64'(peak_count), 64'h5);
`endif
    #2 reset_n = 1'b0;
    #1;
    check_level("async reset", 0);
    check("async reset dout", 64'(dout), 64'h0);
    check_hs("async reset", 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef FIFO_PEAK_CNT_EN
    check("async reset peak", 64'(peak_count), 64'h0);
`endif
    #10;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
